// File: rtl/sha3_pkg.sv
// Shared constants, mode/state types and mode lookup helpers for the SHA3 padder.
package sha3_pkg;

  localparam int LANE_W    = 64;
  localparam int MAX_LANES = 25;
  localparam int MODE_W    = 3;

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } state_e;

  // Reserved encodings fall back to SHA3-256.
  function automatic logic [4:0] rate_lanes(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_SHA3_224: rate_lanes = 5'd18;
      MODE_SHA3_256: rate_lanes = 5'd17;
      MODE_SHA3_384: rate_lanes = 5'd13;
      MODE_SHA3_512: rate_lanes = 5'd9;
      MODE_SHAKE128: rate_lanes = 5'd21;
      MODE_SHAKE256: rate_lanes = 5'd17;
      default:       rate_lanes = 5'd17;
    endcase
  endfunction

  function automatic logic [7:0] suffix(input logic [MODE_W-1:0] mode);
    if (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) suffix = SUFFIX_SHAKE;
    else suffix = SUFFIX_SHA3;
  endfunction

endpackage

// File: rtl/sha3_lane_pad.sv
// Masks one incoming lane to its valid bytes and drops the domain suffix and
// the closing 0x80 into it when they belong in this lane.
module sha3_lane_pad
  import sha3_pkg::LANE_W;
(
  input  logic [LANE_W-1:0]   lane,
  input  logic [LANE_W/8-1:0] tkeep,
  input  logic                last,
  input  logic                final_lane,
  input  logic [7:0]          suffix,
  output logic [LANE_W-1:0]   padded,
  output logic                suffix_placed
);

  localparam int NB = LANE_W / 8;

  logic [3:0] k;

  always_comb begin
    k = 4'd0;
    for (int i = 0; i < NB; i++) k = k + 4'(tkeep[i]);
  end

  // A full last word leaves no room: the suffix spills to the next lane.
  assign suffix_placed = last && (k < 4'(NB));

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    logic [7:0] data_b;
    logic [7:0] sfx_b;
    logic [7:0] end_b;
    assign data_b = (!last || (4'(gi) < k)) ? lane[8*gi +: 8] : 8'h00;
    assign sfx_b  = (last && (4'(gi) == k)) ? suffix : 8'h00;
    assign end_b  = ((gi == NB-1) && final_lane && suffix_placed) ? 8'h80 : 8'h00;
    assign padded[8*gi +: 8] = data_b | sfx_b | end_b;
  end

endmodule

// File: rtl/sha3_pad_block.sv
// Packs an AXI-Stream byte message into rate-sized Keccak blocks with pad10*1
// and a domain suffix, handing each block to the permutation core.
module sha3_pad_block
  import sha3_pkg::*;
(
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [LANE_W-1:0]           s_axis_tdata,
  input  logic [LANE_W/8-1:0]         s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic [MODE_W-1:0]           s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [MAX_LANES*LANE_W-1:0] blk_data,
  output logic [4:0]                  blk_rate,
  output logic                        blk_last,
  output logic                        blk_valid,
  input  logic                        blk_ready
);

  state_e            state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic [4:0]        rate_reg, rate_next;
  logic [7:0]        sfx_reg, sfx_next;
  logic              last_reg, last_next;
  logic              pending_reg, pending_next;
  logic              active_reg, active_next;
  logic              run_reg;
  logic [LANE_W-1:0] lanes_reg  [MAX_LANES];
  logic [LANE_W-1:0] lanes_next [MAX_LANES];

  logic [4:0]        rate_cur, rate_m1, cnt_inc;
  logic [7:0]        sfx_cur;
  logic              accept, handshake, final_lane, placed;
  logic [LANE_W-1:0] padded;

  assign s_axis_tready = run_reg && (state_reg == FILL);
  assign blk_valid     = (state_reg == EMIT);
  assign blk_last      = last_reg;
  assign blk_rate      = rate_reg;

  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_out
    assign blk_data[LANE_W*gi +: LANE_W] = lanes_reg[gi];
  end

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign handshake = blk_valid && blk_ready;

  // Mode is only taken from tuser on the first word of a message.
  assign rate_cur   = active_reg ? rate_reg : rate_lanes(s_axis_tuser);
  assign sfx_cur    = active_reg ? sfx_reg : suffix(s_axis_tuser);
  assign rate_m1    = rate_cur - 5'd1;
  assign cnt_inc    = cnt_reg + 5'd1;
  assign final_lane = (cnt_inc == rate_cur);

  sha3_lane_pad u_lane_pad (
    .lane          (s_axis_tdata),
    .tkeep         (s_axis_tkeep),
    .last          (s_axis_tlast),
    .final_lane    (final_lane),
    .suffix        (sfx_cur),
    .padded        (padded),
    .suffix_placed (placed)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rate_next    = rate_reg;
    sfx_next     = sfx_reg;
    last_next    = last_reg;
    pending_next = pending_reg;
    active_next  = active_reg;
    lanes_next   = lanes_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          lanes_next[cnt_reg] = padded;
          cnt_next    = cnt_inc;
          rate_next   = rate_cur;
          sfx_next    = sfx_cur;
          active_next = 1'b1;
          if (s_axis_tlast) begin
            if (placed) begin
              last_next = 1'b1;
              if (!final_lane) lanes_next[rate_m1][LANE_W-1] = 1'b1;
            end else if (final_lane) begin
              pending_next = 1'b1;
            end else begin
              lanes_next[cnt_inc] = {{(LANE_W-8){1'b0}}, sfx_cur};
              lanes_next[rate_m1][LANE_W-1] = 1'b1;
              last_next = 1'b1;
            end
          end
          if (final_lane || s_axis_tlast) state_next = EMIT;
        end
      end
      EMIT: begin
        if (handshake) begin
          for (int i = 0; i < MAX_LANES; i++) lanes_next[i] = '0;
          cnt_next  = 5'd0;
          last_next = 1'b0;
          if (last_reg) active_next = 1'b0;
          state_next = pending_reg ? PAD : FILL;
        end
      end
      PAD: begin
        lanes_next[0] = {{(LANE_W-8){1'b0}}, sfx_reg};
        lanes_next[rate_reg - 5'd1][LANE_W-1] = 1'b1;
        last_next    = 1'b1;
        pending_next = 1'b0;
        state_next   = EMIT;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= FILL;
      cnt_reg     <= 5'd0;
      rate_reg    <= 5'd0;
      sfx_reg     <= 8'h00;
      last_reg    <= 1'b0;
      pending_reg <= 1'b0;
      active_reg  <= 1'b0;
      run_reg     <= 1'b0;
      for (int i = 0; i < MAX_LANES; i++) lanes_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rate_reg    <= rate_next;
      sfx_reg     <= sfx_next;
      last_reg    <= last_next;
      pending_reg <= pending_next;
      active_reg  <= active_next;
      run_reg     <= 1'b1;
      lanes_reg   <= lanes_next;
    end
  end

endmodule

// File: tb/tb_sha3_pad_block.sv
// Scoreboard bench: messages are padded as byte strings by a reference model,
// split into expected blocks, and compared by an independent output monitor.
module tb_sha3_pad_block;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic [2:0]    s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [1599:0] blk_data;
  logic [4:0]    blk_rate;
  logic          blk_last;
  logic          blk_valid;
  logic          blk_ready;

  sha3_pad_block dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .blk_data      (blk_data),
    .blk_rate      (blk_rate),
    .blk_last      (blk_last),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1599:0] data;
    logic [4:0]    rate;
    logic          last;
  } blk_t;

  typedef logic [7:0] byteq_t[$];

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nblocks = 0;
  int   ready_mode = 0;   // 0 random, 1 held low, 2 held high

  function automatic int model_rate(input int mode);
    case (mode)
      0: return 18;
      1: return 17;
      2: return 13;
      3: return 9;
      4: return 21;
      default: return 17;
    endcase
  endfunction

  function automatic logic [7:0] model_sfx(input int mode);
    return (mode == 4 || mode == 5) ? 8'h1F : 8'h06;
  endfunction

  // Byte-string pad10*1: message || suffix || zeros, last byte of the last block |= 0x80.
  task automatic push_expected(input int mode, input byteq_t msg);
    int     r_bytes;
    int     nblk;
    byteq_t pad;
    blk_t   e;
    r_bytes = model_rate(mode) * 8;
    nblk    = msg.size() / r_bytes + 1;
    pad = msg;
    pad.push_back(model_sfx(mode));
    while (pad.size() < nblk * r_bytes) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int i = 0; i < r_bytes; i++) e.data[8*i +: 8] = pad[b*r_bytes + i];
      e.rate = 5'(model_rate(mode));
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] keep,
                           input logic last, input logic [2:0] user);
    int acc;
    int budget;
    if ($urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge ACLK); #1;
    end
    s_axis_tdata  = d;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    budget = 0;
    forever begin
      acc = int'(s_axis_tready);
      @(posedge ACLK); #1;
      if (acc != 0) break;
      budget++;
      if (budget > 300) begin
        checks++;
        errors++;
        $display("FAIL word_accept: got no tready within 300 cycles, expected acceptance");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_msg(input int mode, input byteq_t msg);
    int          len;
    int          nw;
    int          k;
    logic        last;
    logic [63:0] d;
    logic [7:0]  keep;
    logic [2:0]  user;
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    $display("msg mode=%0d bytes=%0d words=%0d", mode, len, nw);
    push_expected(mode, msg);
    for (int w = 0; w < nw; w++) begin
      last = (w == nw - 1);
      k    = last ? (len - 8*w) : 8;
      d    = {$urandom, $urandom};
      for (int b = 0; b < k; b++) d[8*b +: 8] = msg[8*w + b];
      if (last) keep = 8'((16'h1 << k) - 16'h1);
      else      keep = 8'((16'h1 << $urandom_range(0, 8)) - 16'h1);
      user = (w == 0) ? 3'(mode) : 3'($urandom_range(0, 7));
      send_word(d, keep, last, user);
    end
  endtask

  function automatic byteq_t rand_bytes(input int n);
    byteq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge ACLK); #1;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d blocks still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_valid"},  64'(blk_valid),     64'd0);
    chk({tag, "_last"},   64'(blk_last),      64'd0);
    chk({tag, "_rate"},   64'(blk_rate),      64'd0);
    chk({tag, "_data"},   64'(|blk_data),     64'd0);
  endtask

  // blk_ready driver
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      case (ready_mode)
        0:       blk_ready = ($urandom_range(0, 3) != 0);
        1:       blk_ready = 1'b0;
        default: blk_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: compares on handshake, checks stability while stalled.
  blk_t          mon_e;
  logic          stall_prev = 1'b0;
  logic [1599:0] held_data;
  logic [4:0]    held_rate;
  logic          held_last;

  always @(negedge ACLK) begin
    if (ARESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(blk_valid && blk_data == held_data && blk_rate == held_rate &&
              blk_last == held_last && !s_axis_tready)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0d tready=%0d rate=%0d last=%0d data_same=%0d, expected valid=1 tready=0 and held outputs",
                   blk_valid, s_axis_tready, blk_rate, blk_last, blk_data == held_data);
        end
      end
      if (blk_valid && blk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got block rate=%0d last=%0d, expected none", blk_rate, blk_last);
        end else begin
          mon_e = exp_q.pop_front();
          for (int l = 0; l < 25; l++) begin
            if (blk_data[64*l +: 64] !== mon_e.data[64*l +: 64]) begin
              errors++;
              $display("FAIL blk_data lane %0d: got %h, expected %h", l,
                       blk_data[64*l +: 64], mon_e.data[64*l +: 64]);
              break;
            end
          end
          checks += 2;
          if (blk_rate !== mon_e.rate) begin
            errors++;
            $display("FAIL blk_rate: got %0d, expected %0d", blk_rate, mon_e.rate);
          end
          if (blk_last !== mon_e.last) begin
            errors++;
            $display("FAIL blk_last: got %0d, expected %0d", blk_last, mon_e.last);
          end
          $display("block %0d rate=%0d last=%0d lane0=%h", nblocks, blk_rate, blk_last, blk_data[63:0]);
        end
        nblocks++;
      end
      stall_prev = blk_valid && !blk_ready;
      held_data  = blk_data;
      held_rate  = blk_rate;
      held_last  = blk_last;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byteq_t m;
    int     wait_n;
    ARESET        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("tready_before_rise", 64'(s_axis_tready), 64'd0);
    @(posedge ACLK); #1;
    chk("tready_after_reset", 64'(s_axis_tready), 64'd1);

    // Empty message
    ready_mode = 2;
    m = {};
    send_msg(1, m);
    drain();

    // "abc"
    m = {8'h61, 8'h62, 8'h63};
    send_msg(1, m);
    drain();

    // Exact fill, mode 3 -> extra padding-only block
    ready_mode = 0;
    send_msg(3, rand_bytes(72));
    drain();

    // Boundary: suffix shares the final byte (0x86)
    send_msg(3, rand_bytes(71));
    drain();

    // SHAKE128 with a 5-cycle stall
    ready_mode = 1;
    send_msg(4, rand_bytes(5));
    wait_n = 0;
    while (!blk_valid && wait_n < 100) begin
      @(posedge ACLK); #1;
      wait_n++;
    end
    chk("stall_valid_seen", 64'(blk_valid), 64'd1);
    repeat (5) @(posedge ACLK);
    #1;
    chk("stall_tready", 64'(s_axis_tready), 64'd0);
    ready_mode = 0;
    drain();

    // Reset mid-fill, then "abc"
    for (int w = 0; w < 3; w++)
      send_word({$urandom, $urandom}, 8'hFF, 1'b0, (w == 0) ? 3'd3 : 3'($urandom_range(0, 7)));
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check_reset_outputs("midreset");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("tready_after_midreset", 64'(s_axis_tready), 64'd1);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(1, m);
    drain();

    // Randomised messages in all modes, including reserved encodings
    for (int n = 0; n < 25; n++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0:       len = model_rate(mode) * 8 * $urandom_range(1, 2);
        1:       len = model_rate(mode) * 8 * $urandom_range(1, 2) - $urandom_range(1, 9);
        default: len = $urandom_range(0, 3 * model_rate(mode) * 8);
      endcase
      send_msg(mode, rand_bytes(len));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
